// File: rtl/result_reader_pkg.sv
// Shared definitions for result_reader: state encoding and default widths.
package result_reader_pkg;

  localparam int DEF_DATA_W = 21;
  localparam int DEF_CNT_W  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/result_reader_if.sv
// FIFO read side and output handshake of result_reader.
interface result_reader_if
  import result_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  // FIFO side: rdreq is a one-cycle pulse, q is valid the cycle after (non-show-ahead).
  // Output side: a word transfers on every cycle where out_valid and out_ready are both 1;
  // once raised, out_valid and out_data hold steady until that transfer (or a flush/reset).
  logic              empty;
  logic [DATA_W-1:0] q;
  logic              rdreq;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  empty, q, out_ready,
    output rdreq, out_valid, out_data
  );

  modport slave (
    output empty, q, out_ready,
    input  rdreq, out_valid, out_data
  );

endinterface

// File: rtl/result_reader_word_reg.sv
// Data capture register with load enable and synchronous active-low reset.
module word_reg
  import result_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/result_reader.sv
// Reads one word at a time from a non-show-ahead FIFO and presents it on a valid/ready port.
// Define RESULT_COUNT_EN to build the delivered-word counter; otherwise count is tied to 0.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  result_reader_if.master    bus,
  output logic               busy,
  output logic [CNT_W-1:0]   count,
  output logic [1:0]         dbg_state
);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       load;

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!bus.empty)    state_nx = ST_REQ;
        ST_REQ:                     state_nx = ST_WAIT;
        ST_WAIT:                    state_nx = ST_HOLD;
        ST_HOLD: if (bus.out_ready) state_nx = ST_IDLE;
        default:                    state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  assign bus.rdreq     = (state == ST_REQ);
  assign bus.out_valid = (state == ST_HOLD);
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

  // A flush in WAIT must not overwrite the previously delivered word.
  assign load = (state == ST_WAIT) && !flush;

  word_reg #(
    .DATA_W (DATA_W)
  ) u_word_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (bus.q),
    .q    (bus.out_data)
  );

`ifdef RESULT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             deliver;

  assign deliver = (state == ST_HOLD) && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (deliver) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: cycle table plus hand sequences, FIFO model and word scoreboard.
module tb_result_reader;
  import result_reader_pkg::*;

  localparam int DW = 21;

  typedef struct {
    logic          rst_n;
    logic          flush;
    logic          ready;
    logic          push;
    logic [DW-1:0] wdata;
    logic          e_rdreq;
    logic          e_valid;
    logic          e_busy;
    logic [DW-1:0] e_data;
  } vec_t;

  // clock / reset / inputs
  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  logic ready = 1'b0;

  always #5 clk = ~clk;

  result_reader_if #(.DATA_W(DW)) bus ();
  result_reader_if #(.DATA_W(DW)) bus2 ();

  logic       busy, busy2;
  logic [7:0] count;
  logic [1:0] count2;
  logic [1:0] dbg, dbg2;

  result_reader #(.DATA_W(DW), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .count     (count),
    .dbg_state (dbg)
  );

  result_reader #(.DATA_W(DW), .CNT_W(2)) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus2),
    .busy      (busy2),
    .count     (count2),
    .dbg_state (dbg2)
  );

  // FIFO model, non-show-ahead
  logic [DW-1:0] mem [64];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] q_r    = '0;

  assign bus.empty      = (wr_ptr == rd_ptr);
  assign bus2.empty     = (wr_ptr == rd_ptr);
  assign bus.q          = q_r;
  assign bus2.q         = q_r;
  assign bus.out_ready  = ready;
  assign bus2.out_ready = ready;

  // scoreboard
  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_cnt = 0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] exp_q [$];
  vec_t          vecs [$];

  always @(posedge clk) begin
    if (bus.rdreq) begin
      n_cmp++;
      if (wr_ptr == rd_ptr) begin
        n_err++;
        $display("FAIL underflow: rdreq got 1 with FIFO empty, want 0");
      end else begin
        q_r    <= mem[rd_ptr % 64];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  function automatic vec_t mk(input int rst_n, input int fl, input int rdy, input int psh,
                              input int wd, input int e_rq, input int e_vl, input int e_bs,
                              input int e_dt);
    vec_t v;
    v.rst_n   = (rst_n != 0);
    v.flush   = (fl != 0);
    v.ready   = (rdy != 0);
    v.push    = (psh != 0);
    v.wdata   = DW'(wd);
    v.e_rdreq = (e_rq != 0);
    v.e_valid = (e_vl != 0);
    v.e_busy  = (e_bs != 0);
    v.e_data  = DW'(e_dt);
    return v;
  endfunction

  function automatic logic [31:0] exp_count(input int modulus);
`ifdef RESULT_COUNT_EN
    return 32'(exp_cnt % modulus);
`else
    return 32'(modulus - modulus);
`endif
  endfunction

  // one cycle: drive at negedge, check outputs 1 time unit after the rising edge
  task automatic apply_vec(input vec_t v, input string tag);
    logic [DW-1:0] w;
    @(negedge clk);
    if (prev_valid && v.ready && !v.flush && v.rst_n) begin
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check({tag, "_sb_data"}, 32'(bus.out_data), 32'(w));
      end else begin
        check({tag, "_sb_empty"}, 32'(1), 32'(0));
      end
      exp_cnt++;
    end
    if (!v.rst_n) begin
      exp_cnt = 0;
      exp_q.delete();
    end
    rst   = v.rst_n;
    flush = v.flush;
    ready = v.ready;
    if (v.push) push_word(v.wdata);
    @(posedge clk);
    #1;
    check({tag, "_rdreq"},  32'(bus.rdreq),     32'(v.e_rdreq));
    check({tag, "_valid"},  32'(bus.out_valid), 32'(v.e_valid));
    check({tag, "_busy"},   32'(busy),          32'(v.e_busy));
    check({tag, "_data"},   32'(bus.out_data),  32'(v.e_data));
    check({tag, "_count"},  32'(count),         exp_count(256));
    check({tag, "_count2"}, 32'(count2),        exp_count(4));
    prev_valid = v.e_valid;
  endtask

  initial begin
    // reset, then idle with FIFO empty
    for (int i = 0; i < 2; i++)  vecs.push_back(mk(0,0,0,0,0,        0,0,0,0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1,0,0,0,0,        0,0,0,0));
    // single word
    vecs.push_back(mk(1,0,1,1,'h1ABCDE, 1,0,1,0));
    vecs.push_back(mk(1,0,1,0,0,        0,0,1,0));
    vecs.push_back(mk(1,0,1,0,0,        0,1,1,'h1ABCDE));
    vecs.push_back(mk(1,0,1,0,0,        0,0,0,'h1ABCDE));
    vecs.push_back(mk(1,0,1,0,0,        0,0,0,'h1ABCDE));
    // burst of three words
    vecs.push_back(mk(1,0,1,1,'h000001, 1,0,1,'h1ABCDE));
    vecs.push_back(mk(1,0,1,1,'h0FFFFF, 0,0,1,'h1ABCDE));
    vecs.push_back(mk(1,0,1,1,'h1FFFFF, 0,1,1,'h000001));
    vecs.push_back(mk(1,0,1,0,0,        0,0,0,'h000001));
    vecs.push_back(mk(1,0,1,0,0,        1,0,1,'h000001));
    vecs.push_back(mk(1,0,1,0,0,        0,0,1,'h000001));
    vecs.push_back(mk(1,0,1,0,0,        0,1,1,'h0FFFFF));
    vecs.push_back(mk(1,0,1,0,0,        0,0,0,'h0FFFFF));
    vecs.push_back(mk(1,0,1,0,0,        1,0,1,'h0FFFFF));
    vecs.push_back(mk(1,0,1,0,0,        0,0,1,'h0FFFFF));
    vecs.push_back(mk(1,0,1,0,0,        0,1,1,'h1FFFFF));
    vecs.push_back(mk(1,0,1,0,0,        0,0,0,'h1FFFFF));
    vecs.push_back(mk(1,0,1,0,0,        0,0,0,'h1FFFFF));
    vecs.push_back(mk(1,0,1,0,0,        0,0,0,'h1FFFFF));

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("v%0d", i));

    // back-pressure: five stalled HOLD cycles, then accept (fifth transfer, wraps count2 to 1)
    apply_vec(mk(1,0,0,1,'h0ABCDE, 1,0,1,'h1FFFFF), "bp_req");
    apply_vec(mk(1,0,0,0,0,        0,0,1,'h1FFFFF), "bp_wait");
    apply_vec(mk(1,0,0,0,0,        0,1,1,'h0ABCDE), "bp_hold");
    for (int i = 0; i < 5; i++)
      apply_vec(mk(1,0,0,0,0,      0,1,1,'h0ABCDE), $sformatf("bp_stall%0d", i));
    apply_vec(mk(1,0,1,0,0,        0,0,0,'h0ABCDE), "bp_accept");

    // flush in WAIT: word lost, out_data unchanged
    apply_vec(mk(1,0,1,1,'h155555, 1,0,1,'h0ABCDE), "fw_req");
    apply_vec(mk(1,0,1,0,0,        0,0,1,'h0ABCDE), "fw_wait");
    apply_vec(mk(1,1,1,0,0,        0,0,0,'h0ABCDE), "fw_flush");
    void'(exp_q.pop_front());
    apply_vec(mk(1,0,1,0,0,        0,0,0,'h0ABCDE), "fw_idle");

    // flush in REQ
    apply_vec(mk(1,0,1,1,'h0F0F0F, 1,0,1,'h0ABCDE), "fr_req");
    apply_vec(mk(1,1,1,0,0,        0,0,0,'h0ABCDE), "fr_flush");
    void'(exp_q.pop_front());
    apply_vec(mk(1,0,1,0,0,        0,0,0,'h0ABCDE), "fr_idle");

    // flush beats out_ready in HOLD: not counted
    apply_vec(mk(1,0,1,1,'h012345, 1,0,1,'h0ABCDE), "fh_req");
    apply_vec(mk(1,0,1,0,0,        0,0,1,'h0ABCDE), "fh_wait");
    apply_vec(mk(1,0,1,0,0,        0,1,1,'h012345), "fh_hold");
    apply_vec(mk(1,1,1,0,0,        0,0,0,'h012345), "fh_flush");
    void'(exp_q.pop_front());

    // reset in HOLD beats flush and out_ready
    apply_vec(mk(1,0,0,1,'h1C0FFE, 1,0,1,'h012345), "rh_req");
    apply_vec(mk(1,0,0,0,0,        0,0,1,'h012345), "rh_wait");
    apply_vec(mk(1,0,0,0,0,        0,1,1,'h1C0FFE), "rh_hold");
    apply_vec(mk(0,1,1,0,0,        0,0,0,0),        "rh_reset");
    apply_vec(mk(1,0,0,0,0,        0,0,0,0),        "rh_idle");

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter: DATA_W, default 21, FIFO word width in bits.
REQ-002 Parameter: CNT_W, default 8, delivered-word counter width in bits.
REQ-003 One clock, clk; reset is synchronous and active-low, rst (active-low despite the name).
REQ-004 Port: clk  input  1  system clock, all state updates on the rising edge.
REQ-005 Port: rst  input  1  synchronous active-low reset.
REQ-006 Port: empty  input  1  FIFO empty flag.
REQ-007 Port: q  input  DATA_W  FIFO read data, valid the cycle after rdreq is sampled high (non-show-ahead).
REQ-008 Port: rdreq  output  1  FIFO read request, one-cycle pulse per word.
REQ-009 Port: flush  input  1  synchronous abort; drops any word in flight or held.
REQ-010 Port: out_ready  input  1  consumer accepts the word this cycle.
REQ-011 Port: out_valid  output  1  out_data holds a valid word.
REQ-012 Port: out_data  output  DATA_W  word read from the FIFO.
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: count  output  CNT_W  number of words delivered, modulo 2^CNT_W.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, HOLD; rdreq, out_valid and busy are Moore outputs.
REQ-016 IDLE: empty=0 goes to REQ; otherwise stays in IDLE.
REQ-017 REQ: rdreq=1 for exactly one cycle, then unconditionally goes to WAIT.
REQ-018 WAIT: the data register captures q on this edge, then goes to HOLD.
REQ-019 HOLD: out_valid=1 and out_data stable; out_ready=1 completes the transfer and goes to IDLE; otherwise stays in HOLD.
REQ-020 Latency: empty sampled low at edge N -> out_valid=1 from cycle N+3; minimum 4 cycles per word.
REQ-021 rdreq is never asserted when empty was high in the preceding IDLE cycle, so the FIFO never underflows.
REQ-022 out_ready is ignored outside HOLD.
REQ-023 flush=1 in any state goes to IDLE on the next edge and drops the held word; count is unchanged.
REQ-024 A word already requested in REQ or WAIT is discarded on flush.
REQ-025 flush has priority over out_ready when both are high in HOLD; the transfer is not counted.
REQ-026 out_data keeps its last captured value in IDLE, REQ and WAIT.

Reset
REQ-027 rst=0 at an edge: state IDLE, rdreq=0, out_valid=0, busy=0, out_data=0, count=0.
REQ-028 Reset has priority over flush and all handshakes, including mid-operation in REQ, WAIT or HOLD.

Configuration
REQ-029 Macro RESULT_COUNT_EN defined: count increments by 1 on each HOLD cycle with out_ready=1 and flush=0; it wraps from 2^CNT_W-1 to 0.
REQ-030 Macro RESULT_COUNT_EN undefined: the count port remains present, is driven constant 0, and no counter register is built.

Structure
REQ-031 A shared package holds the state encoding (IDLE=0, REQ=1, WAIT=2, HOLD=3), the default DATA_W=21 and the default CNT_W=8.
REQ-032 Sub-module word_reg holds the DATA_W-bit capture register with load enable and synchronous active-low reset; it is the only sub-module.

Verification
REQ-033 Idle: empty=1 for 10 cycles -> rdreq never asserted, busy=0, out_valid=0.
REQ-034 Single word: FIFO holds 0x1ABCDE, out_ready=1 -> one rdreq pulse, out_valid at cycle +3, out_data=0x1ABCDE, count=1 (macro on).
REQ-035 Back-pressure: out_ready=0 for 5 cycles in HOLD -> out_valid stays 1 and out_data stays stable; out_ready=1 -> IDLE next cycle.
REQ-036 Burst: 3 words 0x000001, 0x0FFFFF, 0x1FFFFF with out_ready=1 -> delivered in order, one every 4 cycles, count=3, no rdreq while empty=1.
REQ-037 Flush and reset: flush in WAIT -> IDLE, word lost, count unchanged; rst=0 in HOLD -> all outputs 0 on the next edge.
REQ-038 Wrap: CNT_W=2 with 5 transfers -> count reads 1; RESULT_COUNT_EN undefined -> count=0 throughout.
